// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe on a programmable tick,
// debounces press and release, and hands accepted key codes out over a valid/ready port.
module keypad_scan #(
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] div_value,
   input  logic [3:0]  row_i,
   output logic [3:0]  col_o,
   output logic [3:0]  key_code_o,
   output logic        key_valid_o,
   input  logic        key_ready_i,
   output logic        key_pressed_o,
   output logic        overflow_o
);

   localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]  col_idx_q, col_idx_d;
   logic [1:0]  row_idx_q, row_idx_d;
   logic [3:0]  deb_cnt_q, deb_cnt_d;
   logic [3:0]  key_code_q, key_code_d;
   logic        key_valid_q, key_valid_d;
   logic        overflow_q, overflow_d;

   logic        tick;
   logic        accept;
   logic        any_row_low;
   logic        row_hit;
   logic [1:0]  low_row;
   logic [3:0]  deb_inc;

   always_comb begin
      tick       = (tick_cnt_q >= div_value);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
   end

   // Lowest-index low row wins when several rows are pulled down together.
   always_comb begin
      low_row = 2'd0;
      if (!row_i[3]) low_row = 2'd3;
      if (!row_i[2]) low_row = 2'd2;
      if (!row_i[1]) low_row = 2'd1;
      if (!row_i[0]) low_row = 2'd0;
   end

   assign any_row_low = ~&row_i;
   assign row_hit     = ~row_i[row_idx_q];
   assign deb_inc     = deb_cnt_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      deb_cnt_d = deb_cnt_q;
      accept    = 1'b0;

      if (tick) begin
         case (state_q)
            SCAN: begin
               if (any_row_low) begin
                  row_idx_d = low_row;
                  deb_cnt_d = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_hit) begin
                  deb_cnt_d = deb_inc;
                  if (deb_inc == DEB_MAX) begin
                     state_d = HELD;
                     accept  = 1'b1;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = SCAN;
               end
            end
            HELD: begin
               if (!row_hit) begin
                  deb_cnt_d = '0;
                  state_d   = RELEASE;
               end
            end
            RELEASE: begin
               if (!row_hit) begin
                  deb_cnt_d = deb_inc;
                  if (deb_inc == DEB_MAX) begin
                     col_idx_d = col_idx_q + 2'd1;
                     state_d   = SCAN;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // A pending code is replaced only if it is consumed in the same cycle; otherwise the new one is dropped.
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overflow_d  = overflow_q;
      if (accept) begin
         if (!key_valid_q || key_ready_i) begin
            key_code_d  = {row_idx_q, col_idx_q};
            key_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (key_valid_q && key_ready_i) begin
         key_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= SCAN;
         tick_cnt_q  <= '0;
         col_idx_q   <= '0;
         row_idx_q   <= '0;
         deb_cnt_q   <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         deb_cnt_q   <= deb_cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign col_o         = ~(4'b0001 << col_idx_q);
   assign key_code_o    = key_code_q;
   assign key_valid_o   = key_valid_q;
   assign overflow_o    = overflow_q;
   assign key_pressed_o = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a physical keypad model drives the rows, and a scoreboard
// queue of expected key codes is drained by a monitor on every valid/ready handshake.
module tb_keypad_scan;

   logic        clk;
   logic        rst;
   logic [31:0] div_value;
   logic [3:0]  row_i;
   logic [3:0]  col_o;
   logic [3:0]  key_code_o;
   logic        key_valid_o;
   logic        key_ready_i;
   logic        key_pressed_o;
   logic        overflow_o;

   logic [15:0] key_mask;    // bit r*4+c set = key at row r, column c held down
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc;         // rising edges since reset was released
   logic [3:0]  exp_q[$];

   keypad_scan #(.DEBOUNCE_TICKS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .div_value    (div_value),
      .row_i        (row_i),
      .col_o        (col_o),
      .key_code_o   (key_code_o),
      .key_valid_o  (key_valid_o),
      .key_ready_i  (key_ready_i),
      .key_pressed_o(key_pressed_o),
      .overflow_o   (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A row reads low when some pressed key on it sits in a column currently driven low.
   function automatic logic [3:0] keypad_rows(input logic [3:0] cols, input logic [15:0] mask);
      logic [3:0] rows;
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
      return rows;
   endfunction

   assign row_i = keypad_rows(col_o, key_mask);

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && key_valid_o && key_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_code: got %0h, expected no code (t=%0t)", key_code_o, $time);
         end else begin
            check("code_handshake", {28'd0, key_code_o}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   // Positions the caller 2 time units after rising edge n (counted from reset release).
   task automatic at_cycle(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset(input logic [31:0] div);
      rst = 1'b0;
      div_value = div;
      key_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_col"},     {28'd0, col_o}, 32'he);
      check({tag, "_code"},    {28'd0, key_code_o}, 32'h0);
      check({tag, "_valid"},   {31'd0, key_valid_o}, 32'd0);
      check({tag, "_pressed"}, {31'd0, key_pressed_o}, 32'd0);
      check({tag, "_ovf"},     {31'd0, overflow_o}, 32'd0);
   endtask

   task automatic run_cycles(input int unsigned n, input bit rnd_ready);
      repeat (n) begin
         @(posedge clk);
         #2;
         if (rnd_ready) key_ready_i = 1'($urandom_range(0, 1));
      end
   endtask

   // Presses (2,1) with no consumer, then releases it; later (0,3) is accepted on the edge after cycle 169.
   task automatic two_key_setup();
      do_reset(32'd9);
      key_mask = 16'h0;
      key_mask[2*4+1] = 1'b1;
      exp_q.push_back(4'h9);
      at_cycle(60);
      at_cycle(65);
      key_mask = 16'h0;
      at_cycle(112);
      key_mask[0*4+3] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      bit seen_valid;
      rst = 1'b0;
      div_value = 32'd9;
      key_ready_i = 1'b0;
      key_mask = 16'h0;
      #1;
      check_reset_outs("por");

      // Idle scan: each column strobe lasts div_value+1 = 10 cycles.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int unsigned k = 1; k <= 45; k++) begin
         at_cycle(k);
         check("idle_col", {28'd0, col_o}, {28'd0, ~(4'b0001 << ((k / 10) % 4))});
      end

      // Clean press of row 2 / column 1: detected at edge 20, accepted at edge 60.
      do_reset(32'd9);
      key_mask[2*4+1] = 1'b1;
      exp_q.push_back(4'h9);
      at_cycle(59);
      check("press_valid_early", {31'd0, key_valid_o}, 32'd0);
      at_cycle(60);
      check("press_valid", {31'd0, key_valid_o}, 32'd1);
      check("press_code", {28'd0, key_code_o}, 32'h9);
      check("press_pressed", {31'd0, key_pressed_o}, 32'd1);
      at_cycle(80);
      check("press_hold_valid", {31'd0, key_valid_o}, 32'd1);
      check("press_hold_code", {28'd0, key_code_o}, 32'h9);
      key_ready_i = 1'b1;
      at_cycle(81);
      key_ready_i = 1'b0;
      check("press_ack_clear", {31'd0, key_valid_o}, 32'd0);
      key_mask = 16'h0;
      at_cycle(150);
      check("press_released", {31'd0, key_pressed_o}, 32'd0);
      check("press_q_empty", exp_q.size(), 32'd0);

      // Bounce: low for the detection tick plus two more, high at the third.
      do_reset(32'd9);
      key_mask[2*4+1] = 1'b1;
      seen_valid = 1'b0;
      at_cycle(45);
      key_mask = 16'h0;
      at_cycle(49);
      check("bounce_col_frozen", {28'd0, col_o}, 32'hd);
      at_cycle(50);
      check("bounce_col_next", {28'd0, col_o}, 32'hb);
      for (int unsigned k = 51; k <= 120; k++) begin
         at_cycle(k);
         if (key_valid_o || key_pressed_o) seen_valid = 1'b1;
      end
      check("bounce_no_valid", {31'd0, seen_valid}, 32'd0);

      // Overflow: second accept while 9 is still pending and unacknowledged.
      two_key_setup();
      at_cycle(169);
      check("ovf_before", {31'd0, overflow_o}, 32'd0);
      at_cycle(170);
      check("ovf_set", {31'd0, overflow_o}, 32'd1);
      check("ovf_code_kept", {28'd0, key_code_o}, 32'h9);
      check("ovf_valid_kept", {31'd0, key_valid_o}, 32'd1);
      at_cycle(175);
      key_ready_i = 1'b1;
      at_cycle(176);
      key_ready_i = 1'b0;
      check("ovf_ack_clear", {31'd0, key_valid_o}, 32'd0);
      check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
      check("ovf_q_empty", exp_q.size(), 32'd0);

      // Ack coinciding with accept: the old code is consumed and the new one loaded.
      two_key_setup();
      exp_q.push_back(4'h3);
      at_cycle(169);
      key_ready_i = 1'b1;
      at_cycle(170);
      key_ready_i = 1'b0;
      check("coinc_valid", {31'd0, key_valid_o}, 32'd1);
      check("coinc_code", {28'd0, key_code_o}, 32'h3);
      check("coinc_ovf", {31'd0, overflow_o}, 32'd0);
      at_cycle(175);
      key_ready_i = 1'b1;
      at_cycle(176);
      key_ready_i = 1'b0;
      check("coinc_ack_clear", {31'd0, key_valid_o}, 32'd0);
      check("coinc_q_empty", exp_q.size(), 32'd0);

      // Reset pulse while debouncing.
      do_reset(32'd9);
      key_mask[2*4+1] = 1'b1;
      at_cycle(35);
      rst = 1'b0;
      #1;
      check_reset_outs("mid_rst");
      key_mask = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen_valid = 1'b0;
      at_cycle(5);
      check("mid_rst_col0", {28'd0, col_o}, 32'he);
      at_cycle(10);
      check("mid_rst_col1", {28'd0, col_o}, 32'hd);
      for (int unsigned k = 11; k <= 100; k++) begin
         at_cycle(k);
         if (key_valid_o) seen_valid = 1'b1;
      end
      check("mid_rst_no_valid", {31'd0, seen_valid}, 32'd0);

      // div_value = 0 ticks on every cycle.
      do_reset(32'd0);
      for (int unsigned k = 1; k <= 8; k++) begin
         at_cycle(k);
         check("div0_col", {28'd0, col_o}, {28'd0, ~(4'b0001 << (k % 4))});
      end

      // Randomized presses with a randomly stalling consumer.
      do_reset(32'd3);
      for (int i = 0; i < 24; i++) begin
         int unsigned div, r, r2, c;
         logic [3:0] exp;
         div = $urandom_range(0, 5);
         div_value = div;
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         key_mask = 16'h0;
         key_mask[r*4+c] = 1'b1;
         exp = 4'(r * 4 + c);
         if ($urandom_range(0, 2) == 0) begin
            r2 = (r + $urandom_range(1, 3)) % 4;
            key_mask[r2*4+c] = 1'b1;
            exp = 4'(((r2 < r) ? r2 : r) * 4 + c);
         end
         exp_q.push_back(exp);
         run_cycles(14 * (div + 1), 1'b1);
         key_mask = 16'h0;
         run_cycles(10 * (div + 1), 1'b1);
      end
      key_ready_i = 1'b1;
      run_cycles(4, 1'b0);
      key_ready_i = 1'b0;
      check("rand_q_empty", exp_q.size(), 32'd0);
      check("rand_no_ovf", {31'd0, overflow_o}, 32'd0);
      check("rand_idle", {31'd0, key_pressed_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
